// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream XOR stage.
package rc4_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } xor_state_t;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Synchronous keystream FIFO, DEPTH x BYTE_W, registered read head (no fall-through).
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]     FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_en, pop_en;

  // Guard against misuse so pointers can never run past each other.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; occupancy is tracked by count_q, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rc4_keystream_xor.sv
// RC4 keystream consumer: buffers keystream bytes, fetches ciphertext from SRAM,
// XORs the two and streams plaintext out over valid/ready, one message per start.
module rc4_keystream_xor
  import rc4_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  msg_len_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              ks_valid_i,
  input  logic [BYTE_W-1:0] ks_byte_i,
  output logic              ks_ready_o,
  output logic              cipher_ren_o,
  output logic [ADDR_W-1:0] cipher_raddr_o,
  input  logic [BYTE_W-1:0] cipher_rdata_i,
  output logic              pt_valid_o,
  output logic [BYTE_W-1:0] pt_byte_o,
  output logic [LEN_W-1:0]  pt_idx_o,
  input  logic              pt_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  xor_state_t        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]  ks_acc_q, ks_acc_d;
  logic              pend_q, pend_d;
  logic [LEN_W-1:0]  pend_idx_q, pend_idx_d;
  logic              pt_valid_q, pt_valid_d;
  logic [BYTE_W-1:0] pt_byte_q, pt_byte_d;
  logic [LEN_W-1:0]  pt_idx_q, pt_idx_d;

  logic [BYTE_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              in_run, start_ok, ks_ready, ks_push, pt_fire, last_fire, issue;

  assign in_run   = (state_q == RUN);
  assign start_ok = (state_q == IDLE) && start_i;

  // Keystream is accepted only while the message still needs bytes, so extra PRGA output is left untouched.
  assign ks_ready = in_run && !fifo_full && (ks_acc_q < len_q);
  assign ks_push  = ks_valid_i && ks_ready;

  assign pt_fire   = pt_valid_q && pt_ready_i;
  assign last_fire = pt_fire && (pt_idx_q == len_q - LEN_W'(1));

  // A read is issued only when its result is guaranteed a free output register on return.
  assign issue = in_run && !fifo_empty && !pend_q && (rd_idx_q < len_q) &&
                 (!pt_valid_q || pt_ready_i);

  rc4_ks_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_ks_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (ks_push),
    .pop   (pend_q),
    .wdata (ks_byte_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Message sequencing: IDLE -> RUN/DONE on start, RUN -> DONE on the last handshake.
  // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (msg_len_i == '0) ? DONE : RUN;
      RUN:     if (last_fire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: message capture, counters, read tracking and the output register.
  always_comb begin
    len_d      = len_q;
    base_d     = base_q;
    rd_idx_d   = rd_idx_q;
    ks_acc_d   = ks_acc_q;
    pend_d     = issue;
    pend_idx_d = issue ? rd_idx_q : pend_idx_q;
    pt_valid_d = pt_valid_q;
    pt_byte_d  = pt_byte_q;
    pt_idx_d   = pt_idx_q;

    if (start_ok) begin
      len_d    = msg_len_i;
      base_d   = base_addr_i;
      rd_idx_d = '0;
      ks_acc_d = '0;
    end
    if (ks_push) ks_acc_d = ks_acc_q + LEN_W'(1);
    if (issue)   rd_idx_d = rd_idx_q + LEN_W'(1);

    // Read data returns the cycle after issue; the keystream head is consumed at the same time.
    if (pend_q) begin
      pt_valid_d = 1'b1;
      pt_byte_d  = cipher_rdata_i ^ fifo_rdata;
      pt_idx_d   = pend_idx_q;
    end else if (pt_fire) begin
      pt_valid_d = 1'b0;
    end
  end

  // State registers; reset aborts any message and drops a pending read.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      base_q     <= '0;
      rd_idx_q   <= '0;
      ks_acc_q   <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      pt_valid_q <= 1'b0;
      pt_byte_q  <= '0;
      pt_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      base_q     <= base_d;
      rd_idx_q   <= rd_idx_d;
      ks_acc_q   <= ks_acc_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      pt_valid_q <= pt_valid_d;
      pt_byte_q  <= pt_byte_d;
      pt_idx_q   <= pt_idx_d;
    end
  end

  assign ks_ready_o     = ks_ready;
  assign cipher_ren_o   = issue;
  assign cipher_raddr_o = issue ? (base_q + ADDR_W'(rd_idx_q)) : '0;
  assign pt_valid_o     = pt_valid_q;
  assign pt_byte_o      = pt_byte_q;
  assign pt_idx_o       = pt_idx_q;
  assign busy_o         = in_run;
  assign done_o         = (state_q == DONE);

endmodule
